// File: rtl/segment_read_engine.sv
// Segment read engine: per-flow descriptor queues, round-robin packet arbitration,
// buffer RAM reads with a 2-entry credit-managed output FIFO and pointer freeing.

module seg_desc_fifo #(
    parameter int W  = 11,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [1<<AW];
    logic [AW:0]  wp, rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

module segment_read_engine #(
    parameter int DATA_WIDTH     = 1024,
    parameter int BUF_SEG_AW     = 10,
    parameter int SEGMENT_SIZE_W = 8,
    parameter int FLOWS_W        = 3,
    parameter int DESC_AW        = 4
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [BUF_SEG_AW:0]                  used_pointer,
    input  logic                                 used_pointer_valid,
    input  logic [FLOWS_W-1:0]                   used_pointer_flow,
    output logic [BUF_SEG_AW+SEGMENT_SIZE_W-1:0] b_raddr,
    input  logic [DATA_WIDTH:0]                  b_rdata,
    output logic [DATA_WIDTH-1:0]                m_rdata,
    output logic                                 m_rvalid,
    input  logic                                 m_rready,
    output logic                                 m_rlast,
    output logic [FLOWS_W-1:0]                   m_rflow,
    output logic [BUF_SEG_AW-1:0]                freed_pointer,
    output logic                                 freed_pointer_valid,
    output logic                                 desc_overflow
);
    localparam int FLOWS = 1 << FLOWS_W;
    localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, RD = 2'd2, WAIT = 2'd3;
    localparam logic [SEGMENT_SIZE_W-1:0] OFF_MAX = '1;

    typedef struct packed {
        logic                  last;
        logic [FLOWS_W-1:0]    flow;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    logic [1:0]                      state;
    logic [FLOWS_W-1:0]              rr_ptr, cur_flow, pick, idx;
    logic [BUF_SEG_AW-1:0]           cur_ptr;
    logic                            cur_last;
    logic [SEGMENT_SIZE_W-1:0]       off, rd_off;
    logic                            iss_stop, rd_pend;
    logic [FLOWS-1:0]                q_empty, q_full, q_pop;
    logic [FLOWS-1:0][BUF_SEG_AW:0]  q_head;
    logic                            any_q, found, issue, seg_end, m_pop;
    logic [2:0]                      occ;
    beat_t                           ff_mem [2];
    beat_t                           wbeat, head;
    logic                            ff_wp, ff_rp;
    logic [1:0]                      ff_cnt;

    for (genvar f = 0; f < FLOWS; f++) begin : g_q
        seg_desc_fifo #(.W(BUF_SEG_AW+1), .AW(DESC_AW)) u_q (
            .clk   (clk),
            .rstn  (rstn),
            .push  (used_pointer_valid && (used_pointer_flow == FLOWS_W'(f))),
            .din   (used_pointer),
            .pop   (q_pop[f]),
            .dout  (q_head[f]),
            .empty (q_empty[f]),
            .full  (q_full[f])
        );
    end

    assign any_q = |(~q_empty);

    always_comb begin
        pick  = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < FLOWS; i++) begin
            idx = rr_ptr + FLOWS_W'(i);
            if (!found && !q_empty[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        q_pop = '0;
        if (state == ARB) q_pop[pick] = 1'b1;
        if (state == WAIT && !q_empty[cur_flow]) q_pop[cur_flow] = 1'b1;
    end

    // The beat leaving this cycle frees its slot, so back-to-back reads keep full rate.
    assign m_pop   = m_rvalid && m_rready;
    assign occ     = {1'b0, ff_cnt} + {2'b0, rd_pend} - {2'b0, m_pop};
    assign issue   = (state == RD) && !iss_stop && (occ < 3'd2);
    assign seg_end = rd_pend && ((rd_off == OFF_MAX) || b_rdata[DATA_WIDTH]);
    assign b_raddr = {cur_ptr, off};

    assign wbeat.last = b_rdata[DATA_WIDTH] | (cur_last && (rd_off == OFF_MAX));
    assign wbeat.flow = cur_flow;
    assign wbeat.data = b_rdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            cur_flow            <= '0;
            cur_ptr             <= '0;
            cur_last            <= 1'b0;
            off                 <= '0;
            rd_off              <= '0;
            iss_stop            <= 1'b0;
            rd_pend             <= 1'b0;
            freed_pointer_valid <= 1'b0;
            freed_pointer       <= '0;
            desc_overflow       <= 1'b0;
        end else begin
            freed_pointer_valid <= seg_end;
            if (seg_end) freed_pointer <= cur_ptr;
            if (used_pointer_valid && q_full[used_pointer_flow]) desc_overflow <= 1'b1;
            // A read issued alongside the segment end is dropped by never marking it pending.
            rd_pend <= issue && !seg_end;
            if (issue) begin
                rd_off <= off;
                if (off == OFF_MAX) iss_stop <= 1'b1;
                else                off      <= off + 1'b1;
            end
            case (state)
                IDLE: if (any_q) state <= ARB;
                ARB: begin
                    {cur_last, cur_ptr} <= q_head[pick];
                    cur_flow            <= pick;
                    rr_ptr              <= pick + 1'b1;
                    off                 <= '0;
                    iss_stop            <= 1'b0;
                    state               <= RD;
                end
                RD: if (seg_end) begin
                    if (!cur_last)  state <= WAIT;
                    else if (any_q) state <= ARB;
                    else            state <= IDLE;
                end
                default: if (!q_empty[cur_flow]) begin
                    {cur_last, cur_ptr} <= q_head[cur_flow];
                    off                 <= '0;
                    iss_stop            <= 1'b0;
                    state               <= RD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) ff_mem[i] <= '0;
            ff_wp  <= 1'b0;
            ff_rp  <= 1'b0;
            ff_cnt <= '0;
        end else begin
            if (rd_pend) begin
                ff_mem[ff_wp] <= wbeat;
                ff_wp         <= ~ff_wp;
            end
            if (m_pop) ff_rp <= ~ff_rp;
            ff_cnt <= ff_cnt + {1'b0, rd_pend} - {1'b0, m_pop};
        end
    end

    assign head     = ff_mem[ff_rp];
    assign m_rvalid = (ff_cnt != 2'd0);
    assign m_rdata  = head.data;
    assign m_rlast  = head.last;
    assign m_rflow  = head.flow;
endmodule

// File: tb/tb_segment_read_engine.sv
// Scoreboard bench for segment_read_engine: a RAM model, expected beats and frees
// queued as descriptors are pushed, compared as the stream and free strobe fire.

module tb_segment_read_engine;
    localparam int DW  = 16;
    localparam int BSA = 6;
    localparam int SSW = 2;
    localparam int FW  = 2;
    localparam int DAW = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [BSA:0]      used_pointer = '0;
    logic              used_pointer_valid = 1'b0;
    logic [FW-1:0]     used_pointer_flow = '0;
    logic [BSA+SSW-1:0] b_raddr;
    logic [DW:0]       b_rdata = '0;
    logic [DW-1:0]     m_rdata;
    logic              m_rvalid;
    logic              m_rready = 1'b1;
    logic              m_rlast;
    logic [FW-1:0]     m_rflow;
    logic [BSA-1:0]    freed_pointer;
    logic              freed_pointer_valid;
    logic              desc_overflow;

    segment_read_engine #(
        .DATA_WIDTH(DW), .BUF_SEG_AW(BSA), .SEGMENT_SIZE_W(SSW), .FLOWS_W(FW), .DESC_AW(DAW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .used_pointer(used_pointer), .used_pointer_valid(used_pointer_valid),
        .used_pointer_flow(used_pointer_flow),
        .b_raddr(b_raddr), .b_rdata(b_rdata),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rlast(m_rlast), .m_rflow(m_rflow),
        .freed_pointer(freed_pointer), .freed_pointer_valid(freed_pointer_valid),
        .desc_overflow(desc_overflow)
    );

    always #5 clk = ~clk;

    logic [DW:0] ram [256];
    always @(posedge clk) b_rdata <= ram[b_raddr];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [FW-1:0] flow;
    } beat_t;

    beat_t          exp_q[$];
    logic [BSA-1:0] free_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] wd(input int p, input int o);
        logic [5:0] pp;
        logic [1:0] oo;
        pp = p[5:0];
        oo = o[1:0];
        return {4'hC, pp, oo, 4'h5};
    endfunction

    // lastidx outside 0..3 leaves every word of the segment without the last bit
    task automatic set_seg(input int p, input int lastidx);
        for (int o = 0; o < 4; o++) ram[p*4+o] = {(o == lastidx), wd(p, o)};
    endtask

    task automatic exp_seg(input int f, input int p, input int n, input bit endpkt);
        beat_t b;
        for (int o = 0; o < n; o++) begin
            b.data = wd(p, o);
            b.last = endpkt && (o == n-1);
            b.flow = f[FW-1:0];
            exp_q.push_back(b);
        end
        free_q.push_back(p[BSA-1:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input int f, input int p, input bit last);
        used_pointer       = {last, p[BSA-1:0]};
        used_pointer_flow  = f[FW-1:0];
        used_pointer_valid = 1'b1;
        tick();
        used_pointer_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && free_q.size() == 0) break;
            tick();
        end
        chk("drain", exp_q.size() + free_q.size(), 0);
        repeat (4) tick();
    endtask

    // monitor: compare on the falling edge, away from the active edge
    initial begin
        beat_t          e;
        logic [BSA-1:0] fp;
        logic           stalled;
        logic [31:0]    held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("stable", {m_rvalid, m_rlast, m_rflow, m_rdata}, held);
                stalled = m_rvalid && !m_rready;
                held    = {m_rvalid, m_rlast, m_rflow, m_rdata};
                if (m_rvalid && m_rready) begin
                    if (exp_q.size() == 0) chk("extra_beat", m_rdata, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("data", m_rdata, e.data);
                        chk("last", m_rlast, e.last);
                        chk("flow", m_rflow, e.flow);
                    end
                end
                if (freed_pointer_valid) begin
                    if (free_q.size() == 0) chk("extra_free", freed_pointer, 0);
                    else begin
                        fp = free_q.pop_front();
                        chk("free", freed_pointer, fp);
                    end
                end
            end
        end
    end

    initial begin
        for (int p = 0; p < 64; p++) set_seg(p, 4);
        repeat (3) tick();
        chk("rst_valid", m_rvalid, 0);
        chk("rst_last", m_rlast, 0);
        chk("rst_free", freed_pointer_valid, 0);
        chk("rst_fptr", freed_pointer, 0);
        chk("rst_ovf", desc_overflow, 0);
        chk("rst_raddr", b_raddr, 0);
        rstn = 1'b1;
        tick();

        // round robin from flow 0: flow1 first, then flow3 (search restarts at 2), then flow0
        set_seg(11, 1); set_seg(13, 2); set_seg(3, 0);
        exp_seg(1, 11, 2, 1);
        exp_seg(3, 13, 3, 1);
        exp_seg(0, 3, 1, 1);
        push_desc(3, 13, 1);
        push_desc(1, 11, 1);
        push_desc(0, 3, 1);
        wait_drain(200);

        // single last segment, last bit on word 2
        set_seg(5, 2);
        exp_seg(0, 5, 3, 1);
        push_desc(0, 5, 1);
        wait_drain(200);

        // two-segment packet on flow 2
        set_seg(7, 4); set_seg(9, 1);
        exp_seg(2, 7, 4, 0);
        exp_seg(2, 9, 2, 1);
        push_desc(2, 7, 0);
        push_desc(2, 9, 1);
        wait_drain(200);

        // last segment without a last bit: m_rlast forced on the final word
        set_seg(12, 4);
        exp_seg(1, 12, 4, 1);
        push_desc(1, 12, 1);
        wait_drain(200);

        // ready toggling every cycle
        set_seg(14, 3);
        exp_seg(2, 14, 4, 1);
        push_desc(2, 14, 1);
        for (int i = 0; i < 30; i++) begin
            m_rready = ~m_rready;
            tick();
        end
        m_rready = 1'b1;
        wait_drain(200);

        // queue overflow: engine held on flow 1, then 17 pushes to flow 0
        m_rready = 1'b0;
        set_seg(10, 3);
        exp_seg(1, 10, 4, 1);
        push_desc(1, 10, 1);
        repeat (6) tick();
        for (int k = 0; k < 17; k++) begin
            set_seg(20 + k, 0);
            if (k < 16) exp_seg(0, 20 + k, 1, 1);
            push_desc(0, 20 + k, 1);
            if (k == 15) chk("ovf_before", desc_overflow, 0);
        end
        chk("ovf_set", desc_overflow, 1);
        m_rready = 1'b1;
        wait_drain(600);
        chk("ovf_sticky", desc_overflow, 1);

        // reset in the middle of a packet
        m_rready = 1'b0;
        set_seg(40, 3);
        push_desc(0, 40, 1);
        repeat (4) tick();
        rstn = 1'b0;
        exp_q.delete();
        free_q.delete();
        #1;
        chk("mid_rst_valid", m_rvalid, 0);
        chk("mid_rst_last", m_rlast, 0);
        chk("mid_rst_free", freed_pointer_valid, 0);
        chk("mid_rst_ovf", desc_overflow, 0);
        chk("mid_rst_raddr", b_raddr, 0);
        repeat (2) tick();
        rstn = 1'b1;
        m_rready = 1'b1;
        tick();
        set_seg(41, 2);
        exp_seg(0, 41, 3, 1);
        push_desc(0, 41, 1);
        wait_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
